// File: rtl/seg7_scan_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : seg7_scan_ctrl_pkg
// Desc     : Scan FSM state encoding and active-low 7-segment patterns (a..g).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg7_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0001100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

endpackage

`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex7seg.sv
//------------------------------------------------------------------------------
// Module   : hex7seg
// Desc     : Combinational hex nibble to active-low 7-segment pattern.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : seg7_scan_ctrl
// Desc     : Multiplexed hex display scanner with a one-deep load buffer that
//            is promoted to the display only at frame boundaries.
//            Define SEG7_LZB_EN to enable leading-zero blanking.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [4*NDIG-1:0] ld_data,
  output logic              ld_ready,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NDIG);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              fd_q, fd_d;

  logic [3:0]        hex_nib;
  logic [6:0]        hex_seg;
  logic              digit_dark;

`ifdef SEG7_LZB_EN
  logic [NDIG-1:0]   lead_zero;
  logic              lz_run;

  // lead_zero[k] is set when nibbles k..NDIG-1 are all zero; digit 0 never blanks.
  always_comb begin
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      lz_run       = lz_run & (disp_q[4*k +: 4] == 4'h0);
      lead_zero[k] = lz_run;
    end
    lead_zero[0] = 1'b0;
  end
`endif

  hex7seg u_hex7seg (
    .hex (hex_nib),
    .seg (hex_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Promotion needs a full buffer and acceptance an empty one, so both never fire together.
  always_comb begin
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (fd_q && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (ld_valid && !pend_full_q) begin
      pend_d      = ld_data;
      pend_full_d = 1'b1;
    end
  end

  // Outputs are computed from next-state so they register on the same edge as the FSM.
  always_comb begin
    hex_nib    = 4'h0;
    digit_dark = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_d == IDX_W'(k)) begin
        hex_nib = disp_q[4*k +: 4];
`ifdef SEG7_LZB_EN
        digit_dark = lead_zero[k];
`endif
      end
    end
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state_d == ST_SHOW && !digit_dark) begin
      seg_d = hex_seg;
      for (int k = 0; k < NDIG; k++) begin
        if (idx_d == IDX_W'(k)) begin
          an_d[k] = 1'b0;
        end
      end
    end
    fd_d = (state_d == ST_SHOW) && (idx_d == IDX_W'(NDIG - 1)) &&
           (cnt_d == CNT_W'(DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign ld_ready   = ~pend_full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_seg7_scan_ctrl
// Desc     : Directed bench for seg7_scan_ctrl with NDIG=4, DIV=4, GAP=1.
//            Define SEG7_LZB_EN for the leading-zero blanking expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GAP   = 1;
  localparam int SLOT  = GAP + DIV;
  localparam int FRAME = NDIG * SLOT;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0001100, PA = 7'b0001000, PB = 7'b1100000,
                         PC = 7'b0110001, PD = 7'b1000010, PE = 7'b0110000,
                         PF = 7'b0111000;

`ifdef SEG7_LZB_EN
  localparam logic [3:0] LIT_LOW2 = 4'b0011;
  localparam logic [3:0] LIT_ZERO = 4'b0001;
`else
  localparam logic [3:0] LIT_LOW2 = 4'b1111;
  localparam logic [3:0] LIT_ZERO = 4'b1111;
`endif

  typedef struct {
    logic [15:0] data;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  lit;    // digits expected to light
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = 16'h0;
  logic        ld_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int   checks = 0;
  int   failures = 0;
  logic rdy_after_fd;
  vec_t vecs [7];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at a negedge where frame_done is high (possibly the current one).
  task automatic wait_fd(input string name);
    int n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) check({name, " frame_done timeout"}, 32'(frame_done), 32'd1);
  endtask

  task automatic load(input string name, input logic [15:0] d);
    int n = 0;
    while ((!ld_ready || frame_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) check({name, " ld_ready timeout"}, 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
    check({name, " ld_ready low after accept"}, 32'(ld_ready), 32'd0);
  endtask

  // Walks one full frame; started=1 means the current negedge is already cycle 1.
  task automatic check_frame(input string name, input logic [27:0] segs,
                             input logic [3:0] lit, input bit started);
    logic [10:0] seen [NDIG];
    int bad_cycles = 0;
    int bad_fd     = 0;
    for (int i = 1; i <= FRAME; i++) begin
      int         slot, dig;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      if (!(started && i == 1)) @(negedge clk);
      if (i == 1) rdy_after_fd = ld_ready;
      slot = (i - 1) % SLOT;
      dig  = (i - 1) / SLOT;
      if (slot < GAP || !lit[dig]) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(4'b0001 << dig);
        exp_seg = segs[dig*7 +: 7];
      end
      if (slot == GAP) seen[dig] = {an, seg};
      if ({an, seg} !== {exp_an, exp_seg}) bad_cycles++;
      if (frame_done !== (i == FRAME)) bad_fd++;
    end
    for (int d = 0; d < NDIG; d++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = lit[d] ? ~(4'b0001 << d) : 4'hF;
      es = lit[d] ? segs[d*7 +: 7] : 7'h7F;
      check($sformatf("%s digit%0d {an,seg}", name, d), 32'(seen[d]), 32'({ea, es}));
    end
    check({name, " mismatched cycles"}, 32'(bad_cycles), 32'd0);
    check({name, " frame_done timing errors"}, 32'(bad_fd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{16'h00A1, {P0, P0, PA, P1}, LIT_LOW2};
    vecs[1] = '{16'h1234, {P1, P2, P3, P4}, 4'hF};
    vecs[2] = '{16'hFEDC, {PF, PE, PD, PC}, 4'hF};
    vecs[3] = '{16'h9876, {P9, P8, P7, P6}, 4'hF};
    vecs[4] = '{16'h0050, {P0, P0, P5, P0}, LIT_LOW2};
    vecs[5] = '{16'hB000, {PB, P0, P0, P0}, 4'hF};
    vecs[6] = '{16'h0000, {P0, P0, P0, P0}, LIT_ZERO};

    // Reset values, then first digit timing after release.
    repeat (2) @(negedge clk);
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first an after release", 32'(an), 32'hE);
    check("first seg after release", 32'(seg), 32'(P0));
    n = 0;
    while (an == 4'hE && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("first digit lit cycles", 32'(n), 32'(DIV));

    wait_fd("period");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check("frame period", 32'(n), 32'(FRAME));

    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d_%h", v, vecs[v].data);
      load(nm, vecs[v].data);
      wait_fd(nm);
      check_frame(nm, vecs[v].segs, vecs[v].lit, 1'b0);
      check({nm, " ld_ready after promote"}, 32'(rdy_after_fd), 32'd1);
    end

    // Held ld_valid with FFFF must be ignored while the buffer is full.
    load("hold", 16'h1234);
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    n = 0;
    while (!ld_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ld_valid = 1'b0;
    check("hold ld_ready returns", 32'(ld_ready), 32'd1);
    check_frame("hold", {P1, P2, P3, P4}, 4'hF, 1'b1);
    check("hold nothing captured", 32'(ld_ready), 32'd1);

    // Load in the frame_done cycle: current frame unchanged, next frame shows it.
    check("fdload at frame_done", 32'(frame_done), 32'd1);
    ld_valid = 1'b1;
    ld_data  = 16'h9876;
    @(negedge clk);
    ld_valid = 1'b0;
    check("fdload accepted", 32'(ld_ready), 32'd0);
    check_frame("fdload old", {P1, P2, P3, P4}, 4'hF, 1'b1);
    check_frame("fdload new", {P9, P8, P7, P6}, 4'hF, 1'b0);

    // Reset during SHOW of digit 2 with the buffer full.
    load("rstmid", 16'hFEDC);
    n = 0;
    while (an != 4'hB && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid reached digit2", 32'(an), 32'hB);
    rst = 1'b1;
    #1;
    check("rstmid an", 32'(an), 32'hF);
    check("rstmid seg", 32'(seg), 32'h7F);
    check("rstmid ld_ready", 32'(ld_ready), 32'd1);
    check("rstmid frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_fd("rstmid");
    check_frame("rstmid after", {P0, P0, P0, P0}, LIT_ZERO, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
